// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES inverse-cipher types, constants and GF(2^8) helpers
package aes_pkg;

    localparam int NB = 4;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [0:127] state_t;

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    function automatic byte_t inv_sbox(input byte_t b);
        byte_t r;
        r = 8'h00;
        case (b)
            8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38;
            8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
            8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87;
            8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
            8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d;
            8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
            8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2;
            8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
            8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16;
            8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
            8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda;
            8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
            8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a;
            8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
            8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02;
            8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
            8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea;
            8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
            8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85;
            8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
            8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89;
            8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
            8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20;
            8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
            8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31;
            8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
            8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d;
            8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
            8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0;
            8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
            8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26;
            8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic byte_t xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t p;
        byte_t x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Byte (r,c) lives at state[8*(r+4c)]; row r rotates right by r columns.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < NB; c++)
                o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
        return o;
    endfunction

    function automatic state_t inv_mix_columns(input state_t s);
        state_t o;
        byte_t a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < NB; c++) begin
            a0 = s[32*c +: 8];
            a1 = s[32*c+8 +: 8];
            a2 = s[32*c+16 +: 8];
            a3 = s[32*c+24 +: 8];
            o[32*c +: 8]    = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[32*c+8 +: 8]  = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[32*c+16 +: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[32*c+24 +: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round (InvMixColumns skipped when last)
module aes_inv_round
    import aes_pkg::*;
(
    input  state_t st,
    input  state_t rk,
    input  logic   last,
    output state_t next_st
);

    state_t t;

    always_comb begin
        t = inv_shift_rows(st);
        for (int k = 0; k < 16; k++)
            t[8*k +: 8] = inv_sbox(t[8*k +: 8]);
        t = t ^ rk;
        next_st = last ? t : inv_mix_columns(t);
    end

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// rtl/aes_inv_cipher_iter.sv - iterative AES inverse cipher, one round per clock
// Optional AES_DEC_KEY_LATCH_EN: snapshot the round-key schedule at block accept.
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int nk = 4,
    parameter int nr = 10
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [0:127]           in,
    input  logic [0:128*(nr+1)-1]  key_d,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:127]           out,
    output logic                   busy
);

    localparam int CW = $clog2(nr + 1);

    if (!((nk == 4 || nk == 6 || nk == 8) && nr == nk + 6)) begin : g_param_err
        $error("aes_inv_cipher_iter: illegal nk/nr combination");
    end

    fsm_t                  fsm;
    logic [CW-1:0]         cnt;
    state_t                st;
    state_t                next_st;
    logic [0:128*(nr+1)-1] keys;
    logic                  accept;

    assign accept = in_valid && in_ready;

`ifdef AES_DEC_KEY_LATCH_EN
    logic [0:128*(nr+1)-1] key_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            key_q <= '0;
        else if (accept)
            key_q <= key_d;
    end

    // The initial AddRoundKey happens on the accept edge, before key_q is loaded.
    assign keys = key_q;
`else
    assign keys = key_d;
`endif

    aes_inv_round u_round (
        .st      (st),
        .rk      (keys[128*int'(cnt) +: 128]),
        .last    (cnt == '0),
        .next_st (next_st)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out       <= '0;
            cnt       <= '0;
            st        <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (accept) begin
                        st       <= in ^ key_d[128*nr +: 128];
                        cnt      <= CW'(nr - 1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        fsm      <= ROUND;
                    end
                end
                ROUND: begin
                    if (cnt == '0) begin
                        out       <= next_st;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        fsm       <= DONE;
                    end else begin
                        st  <= next_st;
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        fsm       <= IDLE;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb/tb_aes_inv_cipher_iter.sv - scoreboard bench for AES-128/192/256 iterative inverse cipher
module tb_aes_inv_cipher_iter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic         busy      [3];
    logic [0:127] din       [3];
    logic [0:127] dout      [3];
    logic [0:1919] key_bus  [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NK = 4 + 2 * g;
        localparam int NR = NK + 6;
        aes_inv_cipher_iter #(.nk(NK), .nr(NR)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in        (din[g]),
            .key_d     (key_bus[g][0:128*(NR+1)-1]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out       (dout[g]),
            .busy      (busy[g])
        );
    end

    logic [0:2047] sbox_tab = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:127] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [0:127] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [0:127] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [0:127] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [0:255] KEYB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:127] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [0:127] PTB  = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [0:127] data;
        bit           chk;
    } exp_t;

    exp_t exp_q [3][$];
    int   total = 0;
    int   bad   = 0;
    int   viol  = 0;

    task automatic check(input string name, input bit ok, input logic [0:127] act, input logic [0:127] req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[8*b +: 8] = sbox_tab[8*int'(w[8*b +: 8]) +: 8];
        return r;
    endfunction

    function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [0:1919] r;
        int            nw;
        nw = 4 * (nk + 7);
        rc = 8'h01;
        r  = '0;
        for (int i = 0; i < nw; i++) begin
            if (i < nk) begin
                w[i] = key[32*i +: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0) begin
                    t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                    rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
                end else if (nk > 6 && i % nk == 4) begin
                    t = subw(t);
                end
                w[i] = w[i-nk] ^ t;
            end
            r[32*i +: 32] = w[i];
        end
        return r;
    endfunction

    function automatic logic [0:255] seq_key(input int nk);
        logic [0:255] k;
        k = '0;
        for (int i = 0; i < 4 * nk; i++) k[8*i +: 8] = 8'(i);
        return k;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rst_n && out_valid[i] && out_ready[i]) begin
                if (exp_q[i].size() == 0) begin
                    check($sformatf("unexpected_out_%0d", i), 1'b0, dout[i], '0);
                end else begin
                    e = exp_q[i].pop_front();
                    if (e.chk)
                        check($sformatf("data_%0d", i), dout[i] === e.data, dout[i], e.data);
                end
            end
        end
    end

`ifndef AES_DEC_KEY_LATCH_EN
    logic [0:1919] key_ref;
    bit            flagged;
    always @(negedge clk) begin
        if (rst_n && in_valid[0] && in_ready[0]) begin
            key_ref = key_bus[0];
            flagged = 1'b0;
        end else if (rst_n && busy[0] && !flagged && key_bus[0] !== key_ref) begin
            flagged = 1'b1;
            viol++;
            $display("protocol: key_d changed inside the round window");
        end
    end
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [0:127] blk, input logic [0:127] want,
                        input bit chk, input bit scramble);
        int n;
        int lat;
        din[i]      = blk;
        in_valid[i] = 1'b1;
        exp_q[i].push_back('{data: want, chk: chk});
        n = 0;
        while (!in_ready[i] && n < 50) begin
            tick();
            n++;
        end
        check("accept_bound", n < 50, n, 50);
        tick();
        in_valid[i] = 1'b0;
        if (scramble)
            for (int k = 0; k < 60; k++) key_bus[i][32*k +: 32] = $urandom();
        lat = 0;
        while (!out_valid[i] && lat < 40) begin
            tick();
            lat++;
        end
        check($sformatf("latency_%0d", i), lat == 10 + 2 * i, lat, 10 + 2 * i);
        if (out_ready[i]) begin
            tick();
            check($sformatf("pulse_%0d", i), out_valid[i] == 1'b0, out_valid[i], 0);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
            din[i]       = '0;
            key_bus[i]   = expand(seq_key(4 + 2 * i), 4 + 2 * i);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst_in_ready_%0d", i), in_ready[i] == 1'b1, in_ready[i], 1);
            check($sformatf("rst_out_valid_%0d", i), out_valid[i] == 1'b0, out_valid[i], 0);
            check($sformatf("rst_busy_%0d", i), busy[i] == 1'b0, busy[i], 0);
            check($sformatf("rst_out_%0d", i), dout[i] == '0, dout[i], '0);
        end

        send(0, CT128, PT, 1'b1, 1'b0);
        send(1, CT192, PT, 1'b1, 1'b0);
        send(2, CT256, PT, 1'b1, 1'b0);

        // Backpressure: a second block waits behind a stalled result and uses a new key.
        out_ready[0] = 1'b0;
        din[0]       = CT128;
        in_valid[0]  = 1'b1;
        exp_q[0].push_back('{data: PT, chk: 1'b1});
        tick();
        din[0] = CTB;
        exp_q[0].push_back('{data: PTB, chk: 1'b1});
        n = 0;
        while (!out_valid[0] && n < 40) begin
            tick();
            n++;
        end
        check("bp_latency", n == 10, n, 10);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_stable", dout[0] == PT, dout[0], PT);
            check("bp_out_valid", out_valid[0] == 1'b1, out_valid[0], 1);
            check("bp_in_ready", in_ready[0] == 1'b0, in_ready[0], 0);
            if (k == 0) key_bus[0] = expand(KEYB, 4);
            tick();
        end
        out_ready[0] = 1'b1;
        tick();
        check("bp_hs_out_valid", out_valid[0] == 1'b0, out_valid[0], 0);
        check("bp_hs_in_ready", in_ready[0] == 1'b1, in_ready[0], 1);
        check("bp_hs_busy", busy[0] == 1'b0, busy[0], 0);
        tick();
        in_valid[0] = 1'b0;
        check("bp_second_accept", busy[0] == 1'b1, busy[0], 1);
        n = 0;
        while (!out_valid[0] && n < 40) begin
            tick();
            n++;
        end
        check("bp_second_latency", n == 10, n, 10);
        tick();
        key_bus[0] = expand(seq_key(4), 4);

        // Reset in the fourth round cycle discards the block in flight.
        din[0]      = CTB;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", busy[0] == 1'b1, busy[0], 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid[0] == 1'b0, out_valid[0], 0);
        check("mid_rst_busy", busy[0] == 1'b0, busy[0], 0);
        check("mid_rst_in_ready", in_ready[0] == 1'b1, in_ready[0], 1);
        tick();
        rst_n = 1'b1;
        tick();
        send(0, CT128, PT, 1'b1, 1'b0);

`ifdef AES_DEC_KEY_LATCH_EN
        send(0, CT128, PT, 1'b1, 1'b1);
`else
        send(0, CT128, PT, 1'b0, 1'b1);
        check("key_window_violation", viol == 1, viol, 1);
`endif
        key_bus[0] = expand(seq_key(4), 4);

        repeat (4) tick();
        for (int i = 0; i < 3; i++)
            check($sformatf("drained_%0d", i), exp_q[i].size() == 0, exp_q[i].size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
